// File: rtl/fs_accel_ofm_packer_pkg.sv
// rtl/fs_accel_ofm_packer_pkg.sv - shared FSM encoding and packing constants for the OFM packer
package fs_accel_ofm_packer_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int LANES          = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WR0     = 3'd2,
      ST_WR1     = 3'd3,
      ST_WR2     = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/fs_accel_byte_packer.sv
// rtl/fs_accel_byte_packer.sv - one lane's 4-byte shift word, LSB-first, zero-padded by clearing
module fs_accel_byte_packer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enb,
   input  logic        clr,
   input  logic        load,
   input  logic [1:0]  sel,
   input  logic [7:0]  din,
   output logic [31:0] word
);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         word <= 32'd0;
      end else if (enb) begin
         if (clr) begin
            word <= 32'd0;
         end else if (load) begin
            word[{sel, 3'b000} +: 8] <= din;
         end
      end
   end

endmodule

// File: rtl/fs_accel_ofm_packer.sv
// rtl/fs_accel_ofm_packer.sv - packs int8 lane triples into 32-bit output-memory writes
// Optional write counter output perf_wr_cnt under macro FS_ACCEL_OFM_PACK_PERF_EN.
module fs_accel_ofm_packer
   import fs_accel_ofm_packer_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 18
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enb,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [ADDR_W-1:0] cfg_lane_stride,
   input  logic [CNT_W-1:0]  cfg_byte_cnt,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [7:0]        in_do_0,
   input  logic [7:0]        in_do_1,
   input  logic [7:0]        in_do_2,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_data,
   output logic              busy,
`ifdef FS_ACCEL_OFM_PACK_PERF_EN
   output logic [31:0]       perf_wr_cnt,
`endif
   output logic              done
);

   state_t              state;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   stride_q;
   logic [ADDR_W-1:0]   word_idx;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    byte_idx;
   logic [CNT_W-1:0]    byte_nxt;
   logic                busy_q;
   logic                done_q;
   logic                accept;
   logic                clr;
   logic [7:0]          lane_din  [LANES];
   logic [31:0]         lane_word [LANES];
   logic [ADDR_W-1:0]   lane_off;

   assign in_rdy   = enb && (state == ST_COLLECT);
   assign out_vld  = enb && (state == ST_WR0 || state == ST_WR1 || state == ST_WR2);
   assign busy     = busy_q;
   assign done     = done_q && enb;
   assign accept   = in_vld && in_rdy;
   assign byte_nxt = byte_idx + CNT_W'(1);

   // Shift words restart empty for every word set, so a short final word reads as zero-padded.
   assign clr = (state == ST_IDLE && start) || (state == ST_WR2 && out_rdy);

   assign lane_din[0] = in_do_0;
   assign lane_din[1] = in_do_1;
   assign lane_din[2] = in_do_2;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      fs_accel_byte_packer u_packer (
         .clk    (clk),
         .resetn (resetn),
         .enb    (enb),
         .clr    (clr),
         .load   (accept),
         .sel    (byte_idx[1:0]),
         .din    (lane_din[k]),
         .word   (lane_word[k])
      );
   end

   always_comb begin
      lane_off = '0;
      out_data = 32'd0;
      out_addr = '0;
      case (state)
         ST_WR0: begin
            out_data = lane_word[0];
            out_addr = base_q + word_idx;
         end
         ST_WR1: begin
            lane_off = stride_q;
            out_data = lane_word[1];
            out_addr = base_q + lane_off + word_idx;
         end
         ST_WR2: begin
            lane_off = {stride_q[ADDR_W-2:0], 1'b0};
            out_data = lane_word[2];
            out_addr = base_q + lane_off + word_idx;
         end
         default: begin
            lane_off = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         base_q   <= '0;
         stride_q <= '0;
         cnt_q    <= '0;
         byte_idx <= '0;
         word_idx <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (enb) begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_q   <= cfg_base_addr;
                  stride_q <= cfg_lane_stride;
                  cnt_q    <= cfg_byte_cnt;
                  byte_idx <= '0;
                  word_idx <= '0;
                  busy_q   <= 1'b1;
                  state    <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (in_vld) begin
                  byte_idx <= byte_nxt;
                  if (byte_nxt[1:0] == 2'b00 || byte_nxt == cnt_q) begin
                     state <= ST_WR0;
                  end
               end
            end
            ST_WR0: if (out_rdy) state <= ST_WR1;
            ST_WR1: if (out_rdy) state <= ST_WR2;
            ST_WR2: begin
               if (out_rdy) begin
                  word_idx <= word_idx + ADDR_W'(1);
                  if (byte_idx == cnt_q) begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     state <= ST_COLLECT;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef FS_ACCEL_OFM_PACK_PERF_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_wr_cnt <= 32'd0;
      end else if (out_vld && out_rdy && perf_wr_cnt != 32'hFFFF_FFFF) begin
         perf_wr_cnt <= perf_wr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/fs_accel_ofm_packer.md
FS_ACCEL_OFM_PACKER -- requirements
Module: fs_accel_ofm_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: output-memory word address width.
REQ-002 SHALL have parameter CNT_W, default 18: per-lane byte counter width.
REQ-003 SHALL have port clk  input  1  clock; reset resetn, synchronous, active-low; clock clk.
REQ-004 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-005 SHALL have port enb  input  1  global enable; low freezes all state.
REQ-006 SHALL have port start  input  1  one-cycle pulse that latches config and begins a job.
REQ-007 SHALL have port cfg_base_addr  input  ADDR_W  word address of lane 0, word 0.
REQ-008 SHALL have port cfg_lane_stride  input  ADDR_W  word offset between lanes.
REQ-009 SHALL have port cfg_byte_cnt  input  CNT_W  bytes per lane in the job; must be at least 1.
REQ-010 SHALL have port in_vld  input  1  int8 triple valid (from elementwise/pool stage).
REQ-011 SHALL have port in_rdy  output  1  triple accepted when in_vld and in_rdy are both high.
REQ-012 SHALL have ports in_do_0/in_do_1/in_do_2  input  8 each  lane bytes.
REQ-013 SHALL have port out_vld  output  1  write request valid.
REQ-014 SHALL have port out_rdy  input  1  memory accepts the write.
REQ-015 SHALL have port out_addr  output  ADDR_W  write word address.
REQ-016 SHALL have port out_data  output  32  packed write word.
REQ-017 SHALL have port busy  output  1  high from start acceptance until done.
REQ-018 SHALL have port done  output  1  one-cycle pulse after the last write is accepted.

Function
REQ-019 SHALL implement FSM states IDLE, COLLECT, WR0, WR1, WR2, DONE.
REQ-020 IDLE: start with enb high SHALL latch cfg_*, clear byte_idx and word_idx, and go to COLLECT; start outside IDLE SHALL be ignored.
REQ-021 COLLECT: in_rdy SHALL be 1; each accepted triple SHALL place lane k's byte at bits [8*b+7:8*b] of lane k's shift word (b = byte_idx mod 4, first byte in LSB) and increment byte_idx.
REQ-022 Transitions from COLLECT: the accept that completes 4 bytes, or the byte_idx reaching cfg_byte_cnt, SHALL move to WR0 next cycle; unfilled bytes of a partial word SHALL be 0x00.
REQ-023 WRk (k=0..2): out_vld SHALL be 1, out_data SHALL be lane k's word, and out_addr SHALL be cfg_base_addr + k*cfg_lane_stride + word_idx, mod 2^ADDR_W.
REQ-024 WRk SHALL advance only when out_rdy is high; WR0->WR1->WR2; after WR2, word_idx SHALL increment and the FSM SHALL go to DONE if all bytes are written, else to COLLECT with the shift words cleared.
REQ-025 DONE: done SHALL be 1 for one cycle, then the FSM SHALL go to IDLE.
REQ-026 in_rdy SHALL be 0 in every state except COLLECT; out_vld SHALL be 0 outside WR0-WR2.
REQ-027 out_vld SHALL stay high and out_addr/out_data SHALL stay stable until accepted.
REQ-028 enb low SHALL force in_rdy=0 and out_vld=0 and hold all registers; resume is lossless.
REQ-029 Throughput SHALL be 1 triple/cycle in COLLECT; a full word set SHALL cost 4 input cycles plus at least 3 write cycles.

Reset
REQ-030 On resetn low at a clock edge: state=IDLE; in_rdy, out_vld, busy, done=0; out_addr=0; out_data=0; counters and shift words=0.
REQ-031 Reset mid-job SHALL discard all partial data without issuing any write.

Configuration
REQ-032 Macro FS_ACCEL_OFM_PACK_PERF_EN defined: SHALL add output perf_wr_cnt (32 bits), reset to 0, incremented per accepted write, saturating at 0xFFFFFFFF.
REQ-033 Macro absent: the port and counter SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the BYTES_PER_WORD=4 and LANES=3 constants.
REQ-035 A single sub-module fs_accel_byte_packer (one lane's 4-byte shift/zero-pad register) SHALL be instantiated 3 times.

Verification
REQ-036 base=0x100, stride=0x40, byte_cnt=4, in bytes 01..04/11..14/21..24, out_rdy=1 -> writes 0x100:0x04030201, 0x140:0x14131211, 0x180:0x24232221, then done.
REQ-037 byte_cnt=6 -> second word set at 0x101/0x141/0x181, lane 0 word 0x00000605 with zero pad, then done.
REQ-038 out_rdy low 5 cycles in WR1 -> out_addr/out_data held stable, in_rdy=0, no duplicate write.
REQ-039 resetn low during WR0 -> next cycle IDLE, out_vld=0, no writes, done never pulses.
REQ-040 base=0xFFFF, stride=1, ADDR_W=16 -> addresses 0xFFFF, 0x0000, 0x0001 (wrap).
REQ-041 start while busy plus enb low 3 cycles mid-COLLECT -> job unaffected, identical output sequence; with PERF_EN, perf_wr_cnt=3 per word set.
